// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART RX frame controller (master) and the
// surrounding pin synchroniser / sampler / deserializer (slave).
interface uart_rx_ctrl_if #(
  parameter int PRESC_WIDTH = 6
);
  logic                   RX_IN;
  logic [PRESC_WIDTH-1:0] PRESCALE;
  logic                   PAR_EN;
  logic                   PAR_TYP;
  logic                   SAMPLED_BIT;
  logic [PRESC_WIDTH-1:0] EDGE_CNT;
  logic [3:0]             BIT_CNT;
  logic                   DAT_SAMP_EN;
  logic                   DESER_EN;
  logic                   DATA_VALID;
  logic                   PAR_ERR;
  logic                   STP_ERR;

  modport master (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP, SAMPLED_BIT,
    output EDGE_CNT, BIT_CNT, DAT_SAMP_EN, DESER_EN, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP, SAMPLED_BIT,
    input  EDGE_CNT, BIT_CNT, DAT_SAMP_EN, DESER_EN, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start detect, oversample/bit counters, framing checks.
// Define UART_RX_PARITY_EN to build the parity state, accumulator and PAR_ERR logic.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_ctrl_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [PRESC_WIDTH-1:0] ONE = PRESC_WIDTH'(1);
  localparam logic [PRESC_WIDTH-1:0] TWO = PRESC_WIDTH'(2);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

  logic [2:0]             state;
  logic [2:0]             state_nx;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] edge_cnt;
  logic [3:0]             bit_cnt;
  logic                   dat_samp_en;
  logic                   deser_en;
  logic                   data_valid;
  logic                   stp_err;
  logic                   par_on;
  logic                   frame_ok;
  logic                   last_edge;
  logic                   pre_edge;

  assign last_edge = (edge_cnt == presc_q - ONE);
  assign pre_edge  = (edge_cnt == presc_q - TWO);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!bus.RX_IN) state_nx = START;
      START:   if (last_edge) state_nx = bus.SAMPLED_BIT ? IDLE : DATA;
      DATA:    if (last_edge && bit_cnt == LAST_DATA) state_nx = par_on ? PARITY : STOP;
      PARITY:  if (last_edge) state_nx = STOP;
      STOP:    if (last_edge) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      presc_q  <= '0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (!bus.RX_IN) begin
          edge_cnt <= ONE;
          presc_q  <= bus.PRESCALE;
        end else begin
          edge_cnt <= '0;
        end
      end else if (state_nx == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end else if (last_edge) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + ONE;
      end
    end
  end

  // Strobes are launched one oversample early so the registered pulse lands on the
  // end-of-bit cycle; the sampler's vote has settled by mid-bit and stays put.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dat_samp_en <= 1'b0;
      deser_en    <= 1'b0;
      data_valid  <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      dat_samp_en <= (state_nx != IDLE);
      deser_en    <= (state == DATA) && pre_edge;
      stp_err     <= (state == STOP) && pre_edge && !bus.SAMPLED_BIT;
      data_valid  <= (state == STOP) && pre_edge && bus.SAMPLED_BIT && frame_ok;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
  logic par_acc;
  logic frame_err;
  logic par_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_acc   <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      par_err <= (state == PARITY) && pre_edge &&
                 ((par_acc ^ bus.SAMPLED_BIT) != par_typ_q);
      if (state == IDLE) begin
        par_acc   <= 1'b0;
        frame_err <= 1'b0;
        if (!bus.RX_IN) begin
          par_en_q  <= bus.PAR_EN;
          par_typ_q <= bus.PAR_TYP;
        end
      end else begin
        if (state == DATA && last_edge) par_acc <= par_acc ^ bus.SAMPLED_BIT;
        if (par_err) frame_err <= 1'b1;
      end
    end
  end

  assign par_on      = par_en_q;
  assign frame_ok    = !frame_err;
  assign bus.PAR_ERR = par_err;
`else
  assign par_on      = 1'b0;
  assign frame_ok    = 1'b1;
  assign bus.PAR_ERR = 1'b0;
`endif

  assign bus.EDGE_CNT    = edge_cnt;
  assign bus.BIT_CNT     = bit_cnt;
  assign bus.DAT_SAMP_EN = dat_samp_en;
  assign bus.DESER_EN    = deser_en;
  assign bus.DATA_VALID  = data_valid;
  assign bus.STP_ERR     = stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit by bit, expected pulses are
// queued at drive time and matched against DESER_EN/DATA_VALID/PAR_ERR/STP_ERR.
module tb_uart_rx_ctrl;

  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  localparam int K_DESER = 1;
  localparam int K_VALID = 2;
  localparam int K_PERR  = 3;
  localparam int K_SERR  = 4;

  typedef struct {
    int         kind;
    int         cycle;
    int         bits;
    int         edge_idx;
    logic [7:0] data;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_ctrl_if #(.PRESC_WIDTH(6)) bus();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESC_WIDTH(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  pulse_t     exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] deser_model = 8'h00;

  // Stand-in for the LSB-first deserializer fed by the controller's strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.DESER_EN) deser_model <= {bus.SAMPLED_BIT, deser_model[7:1]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic scorePulse(input int kind);
    pulse_t e;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_pulse", kind, 0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("pulse_kind", kind, e.kind);
      checkOutput("pulse_cycle", cyc, e.cycle);
      checkOutput("pulse_bit_cnt", 32'(bus.BIT_CNT), e.bits);
      checkOutput("pulse_edge_cnt", 32'(bus.EDGE_CNT), e.edge_idx);
      if (kind == K_VALID) checkOutput("rx_byte", 32'(deser_model), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.DESER_EN)   scorePulse(K_DESER);
      if (bus.DATA_VALID) scorePulse(K_VALID);
      if (bus.PAR_ERR)    scorePulse(K_PERR);
      if (bus.STP_ERR)    scorePulse(K_SERR);
    end
  end

  task automatic pushPulse(input int kind, input int cycle, input int bits,
                           input int edge_idx, input logic [7:0] data);
    pulse_t e;
    e.kind = kind; e.cycle = cycle; e.bits = bits; e.edge_idx = edge_idx; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idleCycles(input int n);
    bus.RX_IN = 1'b1;
    bus.SAMPLED_BIT = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now; abort_at >= 0 pulls reset at that cycle offset.
  task automatic applyStimulus(input logic [7:0] data, input int presc, input bit par_en,
                               input bit par_typ, input bit par_flip, input bit stop_val,
                               input int abort_at);
    logic frame[12];
    bit   eff_par;
    bit   perr;
    int   nbits;
    int   start;
    int   off;
    int   sb;
    eff_par = par_en && PARITY_BUILT;
    perr    = eff_par && par_flip;
    nbits   = 2 + DW + int'(eff_par);
    sb      = 1 + DW + int'(eff_par);
    frame[0] = 1'b0;
    for (int k = 1; k <= DW; k++) frame[k] = data[k-1];
    if (eff_par) frame[DW+1] = (^data) ^ par_typ ^ par_flip;
    frame[sb] = stop_val;
    start = cyc;
    bus.PRESCALE = 6'(presc);
    bus.PAR_EN   = par_en;
    bus.PAR_TYP  = par_typ;
    for (int k = 1; k <= DW; k++) begin
      off = k * presc + presc - 1;
      if (abort_at < 0 || off < abort_at) pushPulse(K_DESER, start + off, k, presc - 1, data);
    end
    if (abort_at < 0) begin
      if (perr) pushPulse(K_PERR, start + (DW + 1) * presc + presc - 1, DW + 1, presc - 1, data);
      if (!stop_val)
        pushPulse(K_SERR, start + sb * presc + presc - 1, sb, presc - 1, data);
      else if (!perr)
        pushPulse(K_VALID, start + sb * presc + presc - 1, sb, presc - 1, data);
    end
    for (int o = 0; o < nbits * presc; o++) begin
      if (o == abort_at) begin
        rst = 1'b0;
        bus.RX_IN = 1'b1;
        bus.SAMPLED_BIT = 1'b1;
        #1;
        checkOutput("reset_mid_frame", {bus.EDGE_CNT, bus.BIT_CNT, bus.DAT_SAMP_EN,
                    bus.DESER_EN, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      bus.RX_IN = frame[o / presc];
      bus.SAMPLED_BIT = frame[o / presc];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyGlitch(input int presc, input int low_cycles);
    bus.PRESCALE = 6'(presc);
    bus.SAMPLED_BIT = 1'b1;
    for (int o = 0; o <= presc + 1; o++) begin
      if (o == presc - 1) begin
        checkOutput("glitch_last_edge", 32'(bus.EDGE_CNT), presc - 1);
        checkOutput("glitch_samp_en_on", 32'(bus.DAT_SAMP_EN), 1);
      end
      if (o == presc) begin
        checkOutput("glitch_idle_edge", 32'(bus.EDGE_CNT), 0);
        checkOutput("glitch_idle_bit", 32'(bus.BIT_CNT), 0);
        checkOutput("glitch_samp_en_off", 32'(bus.DAT_SAMP_EN), 0);
      end
      bus.RX_IN = (o < low_cycles) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.RX_IN = 1'b1;
    bus.SAMPLED_BIT = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", {bus.EDGE_CNT, bus.BIT_CNT, bus.DAT_SAMP_EN,
                bus.DESER_EN, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 0);
    rst = 1'b1;
    idleCycles(3);

    applyStimulus(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    idleCycles(4);
    checkOutput("drain_a5", exp_q.size(), 0);

    applyGlitch(8, 3);
    idleCycles(4);
    checkOutput("drain_glitch", exp_q.size(), 0);

    applyStimulus(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    idleCycles(4);
    checkOutput("drain_parity", exp_q.size(), 0);

    applyStimulus(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idleCycles(2);
    applyStimulus(8'h0F, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idleCycles(4);
    checkOutput("drain_stop", exp_q.size(), 0);

    applyStimulus(8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    applyStimulus(8'hFE, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idleCycles(4);
    checkOutput("drain_b2b", exp_q.size(), 0);

    applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 40);
    idleCycles(3);
    checkOutput("drain_abort", exp_q.size(), 0);
    applyStimulus(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idleCycles(4);
    checkOutput("drain_after_reset", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
